// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched instruction into ALU function/operands and registers it into ID/EX.
// Optional feature: define ID_ILLEGAL_INST_EN to flag undecodable instructions on ex_illegal.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        flush,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_alu_fn,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        ex_wb_en,
    output logic        ex_mem_ren,
    output logic        ex_mem_wen,
    output logic        ex_br,
    output logic        ex_jmp,
    output logic        ex_illegal
);

    localparam logic [4:0] ALU_X = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3,
                           ALU_OR = 5'd4, ALU_XOR = 5'd5, ALU_SLL = 5'd6, ALU_SRL = 5'd7,
                           ALU_SRA = 5'd8, ALU_SLT = 5'd9, ALU_SLTU = 5'd10;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // valid must not depend on ready, and ready may depend on valid.

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_u;

    assign opcode = if_inst[6:0];
    assign rd     = if_inst[11:7];
    assign funct3 = if_inst[14:12];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];
    assign funct7 = if_inst[31:25];
    assign imm_i  = {{20{if_inst[31]}}, if_inst[31:20]};
    assign imm_s  = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign imm_u  = {if_inst[31:12], 12'b0};

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    logic [4:0]  d_fn;
    logic [31:0] d_op1, d_op2;
    logic        d_wb, d_ren, d_wen, d_br, d_jmp, d_bad, d_ill;
    logic        use_rs1, use_rs2;

    always_comb begin
        d_fn    = ALU_X;
        d_op1   = 32'd0;
        d_op2   = 32'd0;
        d_wb    = 1'b0;
        d_ren   = 1'b0;
        d_wen   = 1'b0;
        d_br    = 1'b0;
        d_jmp   = 1'b0;
        d_bad   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_op1   = rf_rs1_data;
                d_op2   = rf_rs2_data;
                d_wb    = 1'b1;
                case (funct3)
                    3'd0:    d_fn = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'd1:    d_fn = ALU_SLL;
                    3'd2:    d_fn = ALU_SLT;
                    3'd3:    d_fn = ALU_SLTU;
                    3'd4:    d_fn = ALU_XOR;
                    3'd5:    d_fn = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'd6:    d_fn = ALU_OR;
                    default: d_fn = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
                d_bad = !((funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                d_op1   = rf_rs1_data;
                d_op2   = (funct3 == 3'd1 || funct3 == 3'd5) ? {27'd0, if_inst[24:20]} : imm_i;
                d_wb    = 1'b1;
                case (funct3)
                    3'd0:    d_fn = ALU_ADD;
                    3'd1:    d_fn = ALU_SLL;
                    3'd2:    d_fn = ALU_SLT;
                    3'd3:    d_fn = ALU_SLTU;
                    3'd4:    d_fn = ALU_XOR;
                    3'd5:    d_fn = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'd6:    d_fn = ALU_OR;
                    default: d_fn = ALU_AND;
                endcase
                d_bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                        ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_LUI: begin
                d_op2 = imm_u;
                d_fn  = ALU_ADD;
                d_wb  = 1'b1;
            end
            OPC_AUIPC: begin
                d_op1 = if_pc;
                d_op2 = imm_u;
                d_fn  = ALU_ADD;
                d_wb  = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                d_op1   = rf_rs1_data;
                d_op2   = imm_i;
                d_fn    = ALU_ADD;
                d_wb    = 1'b1;
                d_ren   = 1'b1;
                d_bad   = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_op1   = rf_rs1_data;
                d_op2   = imm_s;
                d_fn    = ALU_ADD;
                d_wen   = 1'b1;
                d_bad   = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_op1   = rf_rs1_data;
                d_op2   = rf_rs2_data;
                d_fn    = ALU_SUB;
                d_br    = 1'b1;
                d_bad   = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_JAL, OPC_JALR: begin
                use_rs1 = (opcode == OPC_JALR);
                d_op1   = if_pc;
                d_op2   = 32'd4;
                d_fn    = ALU_ADD;
                d_wb    = 1'b1;
                d_jmp   = 1'b1;
                d_bad   = (opcode == OPC_JALR) && (funct3 != 3'd0);
            end
            default: d_bad = 1'b1;
        endcase
        // Undecodable encodings collapse to a NOP that reads nothing and writes nothing.
        if (d_bad) begin
            d_fn    = ALU_X;
            d_wb    = 1'b0;
            d_ren   = 1'b0;
            d_wen   = 1'b0;
            d_br    = 1'b0;
            d_jmp   = 1'b0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
        d_wb = d_wb && (rd != 5'd0);
    end

`ifdef ID_ILLEGAL_INST_EN
    assign d_ill = d_bad;
`else
    assign d_ill = 1'b0;
`endif

    logic adv, haz;

    assign adv = !ex_valid || ex_ready;
    assign haz = ex_valid && ex_mem_ren && (ex_rd != 5'd0) && if_valid &&
                 ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
    assign if_ready = flush || (adv && !haz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= RESET_PC;
            ex_alu_fn     <= ALU_X;
            ex_op1        <= 32'd0;
            ex_op2        <= 32'd0;
            ex_store_data <= 32'd0;
            ex_rd         <= 5'd0;
            ex_wb_en      <= 1'b0;
            ex_mem_ren    <= 1'b0;
            ex_mem_wen    <= 1'b0;
            ex_br         <= 1'b0;
            ex_jmp        <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (flush || (adv && (haz || !if_valid))) begin
            // Empty slot: data fields keep stale values, control flags are cleared.
            ex_valid   <= 1'b0;
            ex_wb_en   <= 1'b0;
            ex_mem_ren <= 1'b0;
            ex_mem_wen <= 1'b0;
            ex_br      <= 1'b0;
            ex_jmp     <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (adv) begin
            ex_valid      <= 1'b1;
            ex_pc         <= if_pc;
            ex_alu_fn     <= d_fn;
            ex_op1        <= d_op1;
            ex_op2        <= d_op2;
            ex_store_data <= rf_rs2_data;
            ex_rd         <= rd;
            ex_wb_en      <= d_wb;
            ex_mem_ren    <= d_ren;
            ex_mem_wen    <= d_wen;
            ex_br         <= d_br;
            ex_jmp        <= d_jmp;
            ex_illegal    <= d_ill;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: scoreboard of expected ID/EX contents, hazard, stall/flush and reset checks.
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int W = 145;
    localparam logic [5:0] F_WB = 6'b100000, F_REN = 6'b010000, F_WEN = 6'b001000,
                           F_BR = 6'b000100, F_JMP = 6'b000010, F_ILL = 6'b000001;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_LOAD = 7'b0000011, OPC_JALR = 7'b1100111;
`ifdef ID_ILLEGAL_INST_EN
    localparam logic [5:0] ILL_EXP = F_ILL;
`else
    localparam logic [5:0] ILL_EXP = 6'b000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_inst = 32'd0;
    logic        flush = 1'b0;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data = 32'd0;
    logic [31:0] rf_rs2_data = 32'd0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_store_data;
    logic [4:0]  ex_alu_fn, ex_rd;
    logic        ex_wb_en, ex_mem_ren, ex_mem_wen, ex_br, ex_jmp, ex_illegal;

    id_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .flush(flush),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_alu_fn(ex_alu_fn),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_wb_en(ex_wb_en), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
        .ex_br(ex_br), .ex_jmp(ex_jmp), .ex_illegal(ex_illegal)
    );

    // clock
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic opk, input logic [31:0] pc, input logic [4:0] fn,
                                        input logic [31:0] op1, input logic [31:0] op2,
                                        input logic [31:0] sd, input logic [4:0] rd,
                                        input logic [5:0] fl);
        return {opk, pc, fn, op1, op2, sd, rd, fl};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // scoreboard: compare ID/EX against the oldest expectation whenever EX consumes it
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(ex_valid), 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("pc", ex_pc, e[143:112]);
                check("fn", 32'(ex_alu_fn), 32'(e[111:107]));
                check("rd", 32'(ex_rd), 32'(e[10:6]));
                check("flags", 32'({ex_wb_en, ex_mem_ren, ex_mem_wen, ex_br, ex_jmp, ex_illegal}),
                      32'(e[5:0]));
                if (e[144]) begin
                    check("op1", ex_op1, e[106:75]);
                    check("op2", ex_op2, e[74:43]);
                end
                if (e[3]) check("store_data", ex_store_data, e[42:11]);
            end
        end
    end

    // driver: offer one instruction, push its expectation on acceptance; waits = cycles refused
    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [W-1:0] e, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        if_valid = 1'b1;
        if_pc = pc;
        if_inst = inst;
        rf_rs1_data = d1;
        rf_rs2_data = d2;
        while (!acc && waits < 20) begin
            @(negedge clk);
            if (if_ready) begin
                acc = 1'b1;
                exp_q.push_back(e);
            end else begin
                waits++;
            end
        end
        check("accepted", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        logic [31:0] d1, d2, inst;
        logic [4:0] fn_tab[8];
        fn_tab = '{5'd1, 5'd6, 5'd9, 5'd10, 5'd5, 5'd7, 5'd4, 5'd3};

        // reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_pc", ex_pc, RST_PC);
        check("rst_fn", 32'(ex_alu_fn), 32'd0);
        check("rst_op1", ex_op1, 32'd0);
        check("rst_rd", 32'(ex_rd), 32'd0);
        check("rst_flags", 32'({ex_wb_en, ex_mem_ren, ex_mem_wen, ex_br, ex_jmp, ex_illegal}), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;

        // addi x1,x0,5
        send(32'h0, 32'h0050_0093, 32'd0, 32'd0, mk(1, 32'h0, 5'd1, 32'd0, 32'd5, 32'd0, 5'd1, F_WB), w);
        check("addi_wait", 32'(w), 32'd0);
        // sub x3,x1,x2
        inst = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
        send(32'h4, inst, 32'd9, 32'd4, mk(1, 32'h4, 5'd2, 32'd9, 32'd4, 32'd0, 5'd3, F_WB), w);
        check("rs1_addr", 32'(rf_rs1_addr), 32'd1);
        check("rs2_addr", 32'(rf_rs2_addr), 32'd2);
        // srai x3,x1,2
        send(32'h8, enc_i(12'h402, 5'd1, 3'd5, 5'd3, OPC_OPIMM), 32'h8000_0000, 32'd0,
             mk(1, 32'h8, 5'd8, 32'h8000_0000, 32'd2, 32'd0, 5'd3, F_WB), w);
        // R-type funct3 sweep, back to back, random operands
        for (int i = 0; i < 8; i++) begin
            d1 = $urandom;
            d2 = $urandom;
            send(32'h10 + 32'(i * 4), enc_r(7'h00, 5'd2, 5'd1, 3'(i), 5'd4), d1, d2,
                 mk(1, 32'h10 + 32'(i * 4), fn_tab[i], d1, d2, 32'd0, 5'd4, F_WB), w);
            check("r_throughput", 32'(w), 32'd0);
        end
        // addi x0,x1,-1: rd=0 suppresses writeback
        send(32'h40, enc_i(12'hFFF, 5'd1, 3'd0, 5'd0, OPC_OPIMM), 32'd7, 32'd0,
             mk(1, 32'h40, 5'd1, 32'd7, 32'hFFFF_FFFF, 32'd0, 5'd0, 6'd0), w);
        // lui x7,0x12345
        send(32'h44, enc_u(20'h12345, 5'd7, OPC_LUI), $urandom, $urandom,
             mk(1, 32'h44, 5'd1, 32'd0, 32'h1234_5000, 32'd0, 5'd7, F_WB), w);
        // auipc x2,1
        send(32'h200, enc_u(20'h00001, 5'd2, OPC_AUIPC), 32'd0, 32'd0,
             mk(1, 32'h200, 5'd1, 32'h200, 32'h0000_1000, 32'd0, 5'd2, F_WB), w);
        // jal x1,8 at 0x100
        send(32'h100, 32'h0080_00EF, 32'd0, 32'd0,
             mk(1, 32'h100, 5'd1, 32'h100, 32'd4, 32'd0, 5'd1, F_WB | F_JMP), w);
        // jalr x1,0(x2)
        send(32'h104, enc_i(12'h000, 5'd2, 3'd0, 5'd1, OPC_JALR), 32'h55, 32'd0,
             mk(1, 32'h104, 5'd1, 32'h104, 32'd4, 32'd0, 5'd1, F_WB | F_JMP), w);
        // sw x2,32(x1)
        send(32'h108, {7'b0000001, 5'd2, 5'd1, 3'd2, 5'd0, 7'b0100011}, 32'h1000, 32'hCAFE,
             mk(1, 32'h108, 5'd1, 32'h1000, 32'd32, 32'hCAFE, 5'd0, F_WEN), w);
        // beq x1,x2,+32
        send(32'h10C, {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd0, 7'b1100011}, 32'd11, 32'd3,
             mk(1, 32'h10C, 5'd2, 32'd11, 32'd3, 32'd0, 5'd0, F_BR), w);

        // load-use: lw x5,0(x1) then add x6,x5,x0
        send(32'h110, enc_i(12'h000, 5'd1, 3'd2, 5'd5, OPC_LOAD), 32'h40, 32'd0,
             mk(1, 32'h110, 5'd1, 32'h40, 32'd0, 32'd0, 5'd5, F_WB | F_REN), w);
        if_valid = 1'b1;
        if_pc = 32'h114;
        if_inst = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6);
        rf_rs1_data = 32'h77;
        rf_rs2_data = 32'd0;
        @(negedge clk);
        check("haz_if_ready", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bubble_valid", 32'(ex_valid), 32'd0);
        check("bubble_ren", 32'(ex_mem_ren), 32'd0);
        check("after_bubble_ready", 32'(if_ready), 32'd1);
        exp_q.push_back(mk(1, 32'h114, 5'd1, 32'h77, 32'd0, 32'd0, 5'd6, F_WB));
        @(posedge clk);
        #1;
        if_valid = 1'b0;

        // load followed by an instruction that reads no register: no bubble
        send(32'h118, enc_i(12'h004, 5'd1, 3'd2, 5'd5, OPC_LOAD), 32'h80, 32'd0,
             mk(1, 32'h118, 5'd1, 32'h80, 32'd4, 32'd0, 5'd5, F_WB | F_REN), w);
        send(32'h11C, enc_u(20'h00005, 5'd5, OPC_LUI), 32'd0, 32'd0,
             mk(1, 32'h11C, 5'd1, 32'd0, 32'h0000_5000, 32'd0, 5'd5, F_WB), w);
        check("lui_no_haz", 32'(w), 32'd0);
        // load to x0 never creates a hazard
        send(32'h120, enc_i(12'h000, 5'd1, 3'd2, 5'd0, OPC_LOAD), 32'h90, 32'd0,
             mk(1, 32'h120, 5'd1, 32'h90, 32'd0, 32'd0, 5'd0, F_REN), w);
        send(32'h124, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6), 32'd0, 32'd0,
             mk(1, 32'h124, 5'd1, 32'd0, 32'd0, 32'd0, 5'd6, F_WB), w);
        check("x0_no_haz", 32'(w), 32'd0);

        // unknown opcode 7'b1111111
        send(32'h300, 32'h0000_007F, $urandom, $urandom,
             mk(0, 32'h300, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, ILL_EXP), w);
        idle(2);

        // stall with flush in the second stalled cycle
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_pc = 32'h400;
        if_inst = enc_i(12'h055, 5'd0, 3'd0, 5'd9, OPC_OPIMM);
        rf_rs1_data = 32'd0;
        @(posedge clk);
        #1;
        if_pc = 32'h404;
        if_inst = enc_i(12'h066, 5'd0, 3'd0, 5'd10, OPC_OPIMM);
        @(negedge clk);
        check("stall1_valid", 32'(ex_valid), 32'd1);
        check("stall1_pc", ex_pc, 32'h400);
        check("stall1_op2", ex_op2, 32'h55);
        check("stall1_if_ready", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("stall2_valid", 32'(ex_valid), 32'd1);
        check("stall2_pc", ex_pc, 32'h400);
        check("stall2_op2", ex_op2, 32'h55);
        check("flush_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_wb", 32'(ex_wb_en), 32'd0);
        @(posedge clk);
        #1;

        // asynchronous reset while an instruction is held
        if_valid = 1'b1;
        if_pc = 32'h500;
        if_inst = enc_i(12'h011, 5'd0, 3'd0, 5'd3, OPC_OPIMM);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ex_valid), 32'd0);
        check("async_rst_pc", ex_pc, RST_PC);
        check("async_rst_fn", 32'(ex_alu_fn), 32'd0);
        check("async_rst_wb", 32'(ex_wb_en), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ex_ready = 1'b1;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
